// File: rtl/tx_sr_if.sv
`default_nettype none
// ============================================================================
// Module   : tx_sr_if
// Brief    : Controller-side bundle of the I2C slave transmit shift register.
// Revision : 1.0
// ============================================================================
interface tx_sr_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tx_enable;
    logic                  load_data;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_out;
    logic [3:0]            bit_count;
    logic                  byte_done;
    logic                  ack_valid;
    logic                  ack_bit;

    modport master (
        output tx_enable, load_data, tx_data,
        input  tx_out, bit_count, byte_done, ack_valid, ack_bit
    );

    modport slave (
        input  tx_enable, load_data, tx_data,
        output tx_out, bit_count, byte_done, ack_valid, ack_bit
    );
endinterface
`default_nettype wire

// File: rtl/tx_sr.sv
`default_nettype none
// ============================================================================
// Module   : tx_sr
// Brief    : I2C slave read-path shift register: MSB-first on SCL falls, then
//            samples ACK/NACK. Optional 2-flop SCL/SDA sync: TX_SCL_SYNC_EN.
// Revision : 1.0
// ============================================================================
module tx_sr #(
    parameter int DATA_WIDTH = 8
) (
    input  wire     clk,
    input  wire     n_rst,
    input  wire     scl,
    input  wire     sda_in,
    tx_sr_if.slave  bus
);
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_SHIFT    = 2'd1;
    localparam logic [1:0] c_ST_ACK_WAIT = 2'd2;
    localparam logic [3:0] c_LAST        = 4'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] c_ONES = '1;

    logic                  w_scl_cur;
    logic                  w_sda_s;
    logic                  r_scl_prev;
    logic                  w_scl_rise;
    logic                  w_scl_fall;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DATA_WIDTH-1:0] w_shreg_nxt;
    logic [3:0]            r_bit_count;
    logic [3:0]            w_bit_count_nxt;
    logic                  r_byte_done;
    logic                  w_byte_done_nxt;
    logic                  r_ack_valid;
    logic                  w_ack_valid_nxt;
    logic                  r_ack_bit;
    logic                  w_ack_bit_nxt;

`ifdef TX_SCL_SYNC_EN
    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;

    // Reset to 1 (idle bus level) so no edge is seen on reset release
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl};
            r_sda_sync <= {r_sda_sync[0], sda_in};
        end
    end

    assign w_scl_cur = r_scl_sync[1];
    assign w_sda_s   = r_sda_sync[1];
`else
    assign w_scl_cur = scl;
    assign w_sda_s   = sda_in;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_scl_prev <= 1'b1;
        end else begin
            r_scl_prev <= w_scl_cur;
        end
    end

    assign w_scl_rise = w_scl_cur & ~r_scl_prev;
    assign w_scl_fall = ~w_scl_cur & r_scl_prev;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.load_data) w_state_nxt = c_ST_SHIFT;
            end
            c_ST_SHIFT: begin
                if (!bus.tx_enable)                          w_state_nxt = c_ST_IDLE;
                else if (w_scl_fall && r_bit_count == c_LAST) w_state_nxt = c_ST_ACK_WAIT;
            end
            c_ST_ACK_WAIT: begin
                if (!bus.tx_enable || w_scl_rise) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_shreg_nxt     = r_shreg;
        w_bit_count_nxt = r_bit_count;
        w_byte_done_nxt = 1'b0;
        w_ack_valid_nxt = 1'b0;
        w_ack_bit_nxt   = r_ack_bit;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.load_data) begin
                    w_shreg_nxt     = bus.tx_data;
                    w_bit_count_nxt = 4'd0;
                end
            end
            c_ST_SHIFT: begin
                if (!bus.tx_enable) begin
                    w_shreg_nxt     = c_ONES;
                    w_bit_count_nxt = 4'd0;
                end else if (w_scl_rise) begin
                    w_bit_count_nxt = r_bit_count + 4'd1;
                end else if (w_scl_fall) begin
                    // A fall before the first rise keeps the MSB on the line
                    if (r_bit_count == c_LAST) begin
                        w_shreg_nxt     = c_ONES;
                        w_byte_done_nxt = 1'b1;
                    end else if (r_bit_count != 4'd0) begin
                        w_shreg_nxt = {r_shreg[DATA_WIDTH-2:0], 1'b1};
                    end
                end
            end
            c_ST_ACK_WAIT: begin
                if (!bus.tx_enable) begin
                    w_shreg_nxt     = c_ONES;
                    w_bit_count_nxt = 4'd0;
                end else if (w_scl_rise) begin
                    w_ack_bit_nxt   = w_sda_s;
                    w_ack_valid_nxt = 1'b1;
                    w_bit_count_nxt = 4'd0;
                end
            end
            default: begin
                w_shreg_nxt     = c_ONES;
                w_bit_count_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_shreg     <= c_ONES;
            r_bit_count <= 4'd0;
            r_byte_done <= 1'b0;
            r_ack_valid <= 1'b0;
            r_ack_bit   <= 1'b1;
        end else begin
            r_shreg     <= w_shreg_nxt;
            r_bit_count <= w_bit_count_nxt;
            r_byte_done <= w_byte_done_nxt;
            r_ack_valid <= w_ack_valid_nxt;
            r_ack_bit   <= w_ack_bit_nxt;
        end
    end

    assign bus.tx_out    = r_shreg[DATA_WIDTH-1];
    assign bus.bit_count = r_bit_count;
    assign bus.byte_done = r_byte_done;
    assign bus.ack_valid = r_ack_valid;
    assign bus.ack_bit   = r_ack_bit;
endmodule
`default_nettype wire

// File: tb/tb_tx_sr.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_sr
// Brief    : Scoreboard bench for tx_sr; honours TX_SCL_SYNC_EN for latency.
// Revision : 1.0
// ============================================================================
module tb_tx_sr;
`ifdef TX_SCL_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int HALF = 6;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic scl = 1'b1;
    logic sda_in = 1'b1;
    logic scl_q = 1'b1;

    int total = 0;
    int bad = 0;

    logic bit_q[$];
    logic done_q[$];
    logic ack_q[$];

    tx_sr_if #(.DATA_WIDTH(8)) bus ();

    tx_sr #(.DATA_WIDTH(8)) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .scl    (scl),
        .sda_in (sda_in),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: tx_out at every SCL rise, byte_done and ack_valid pulses
    always @(negedge clk) begin
        if (n_rst) begin
            if (scl && !scl_q) begin
                if (bit_q.size() == 0) chk("unexpected_rise", 1, 0);
                else chk("tx_out_at_rise", {31'd0, bus.tx_out}, {31'd0, bit_q.pop_front()});
            end
            if (bus.byte_done) begin
                if (done_q.size() == 0) chk("unexpected_byte_done", 1, 0);
                else chk("tx_out_at_byte_done", {31'd0, bus.tx_out}, {31'd0, done_q.pop_front()});
            end
            if (bus.ack_valid) begin
                if (ack_q.size() == 0) chk("unexpected_ack_valid", 1, 0);
                else chk("ack_bit", {31'd0, bus.ack_bit}, {31'd0, ack_q.pop_front()});
            end
        end
        scl_q = scl;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic do_load(input logic [7:0] d, input bit with_fall);
        bus.tx_data   = d;
        bus.load_data = 1'b1;
        if (with_fall) scl = 1'b0;
        tick();
        bus.load_data = 1'b0;
        chk("load_msb", {31'd0, bus.tx_out}, {31'd0, d[7]});
        chk("load_bit_count", {28'd0, bus.bit_count}, 0);
    endtask

    task automatic fall_half();
        scl = 1'b0;
        wait_n(HALF);
    endtask

    task automatic rise_half(input logic exp_bit, input int exp_bc);
        bit_q.push_back(exp_bit);
        scl = 1'b1;
        wait_n(LAT);
        if (exp_bc >= 0) chk("bit_count", {28'd0, bus.bit_count}, exp_bc);
        wait_n(HALF - LAT);
    endtask

    task automatic send_bits(input logic [7:0] d, input int from, input int to);
        for (int k = from; k <= to; k++) begin
            fall_half();
            rise_half(d[8-k], k);
        end
    endtask

    // Ninth clock: release + byte_done on the fall, ACK sample on the rise
    task automatic ack_cycle(input logic sda, input bit b2b);
        int n;
        done_q.push_back(1'b1);
        ack_q.push_back(sda);
        scl    = 1'b0;
        sda_in = sda;
        n = 0;
        do begin tick(); n++; end while (!bus.byte_done && n < 10);
        chk("byte_done_latency", n, LAT);
        wait_n(HALF - n);
        bit_q.push_back(1'b1);
        scl = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus.ack_valid && n < 10);
        chk("ack_valid_latency", n, LAT);
        chk("ack_bit_count", {28'd0, bus.bit_count}, 0);
        sda_in = 1'b1;
        if (!b2b) wait_n(HALF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tx_enable = 1'b0;
        bus.load_data = 1'b0;
        bus.tx_data   = 8'h00;
        wait_n(3);
        chk("rst_tx_out", {31'd0, bus.tx_out}, 1);
        chk("rst_bit_count", {28'd0, bus.bit_count}, 0);
        chk("rst_byte_done", {31'd0, bus.byte_done}, 0);
        chk("rst_ack_valid", {31'd0, bus.ack_valid}, 0);
        chk("rst_ack_bit", {31'd0, bus.ack_bit}, 1);
        n_rst = 1'b1;
        bus.tx_enable = 1'b1;
        wait_n(4);

        // 0xA5 with ACK, 0x5A with NACK, 0x0F with ACK
        do_load(8'hA5, 1'b0);
        send_bits(8'hA5, 1, 8);
        ack_cycle(1'b0, 1'b0);
        do_load(8'h5A, 1'b0);
        send_bits(8'h5A, 1, 8);
        ack_cycle(1'b1, 1'b0);
        do_load(8'h0F, 1'b0);
        send_bits(8'h0F, 1, 8);
        ack_cycle(1'b0, 1'b0);

        // Asynchronous reset after three bits of 0x00
        do_load(8'h00, 1'b0);
        send_bits(8'h00, 1, 3);
        n_rst = 1'b0;
        #1;
        chk("midrst_tx_out", {31'd0, bus.tx_out}, 1);
        chk("midrst_bit_count", {28'd0, bus.bit_count}, 0);
        chk("midrst_byte_done", {31'd0, bus.byte_done}, 0);
        chk("midrst_ack_valid", {31'd0, bus.ack_valid}, 0);
        chk("midrst_ack_bit", {31'd0, bus.ack_bit}, 1);
        wait_n(2);
        n_rst = 1'b1;
        wait_n(4);

        // Abort 0x3C after three rises
        do_load(8'h3C, 1'b0);
        send_bits(8'h3C, 1, 3);
        bus.tx_enable = 1'b0;
        tick();
        chk("abort_tx_out", {31'd0, bus.tx_out}, 1);
        chk("abort_bit_count", {28'd0, bus.bit_count}, 0);
        for (int k = 0; k < 6; k++) begin
            fall_half();
            rise_half(1'b1, -1);
        end
        chk("abort_idle_bit_count", {28'd0, bus.bit_count}, 0);
        bus.tx_enable = 1'b1;
        wait_n(2);

        // load_data during SHIFT is ignored
        do_load(8'hFF, 1'b0);
        send_bits(8'hFF, 1, 3);
        bus.tx_data   = 8'h00;
        bus.load_data = 1'b1;
        tick();
        bus.load_data = 1'b0;
        wait_n(LAT + 1);
        chk("midload_tx_out", {31'd0, bus.tx_out}, 1);
        chk("midload_bit_count", {28'd0, bus.bit_count}, 3);
        send_bits(8'hFF, 4, 8);
        ack_cycle(1'b0, 1'b0);

        // load_data coincident with an SCL fall in IDLE: first bit held
        do_load(8'h96, 1'b1);
        wait_n(LAT + 1);
        chk("coinc_tx_out", {31'd0, bus.tx_out}, 1);
        chk("coinc_bit_count", {28'd0, bus.bit_count}, 0);
        wait_n(HALF);
        rise_half(1'b1, 1);
        send_bits(8'h96, 2, 8);
        ack_cycle(1'b1, 1'b0);

        // Back-to-back: 0x00 loaded in the first IDLE cycle after ack_valid
        do_load(8'hFF, 1'b0);
        send_bits(8'hFF, 1, 8);
        ack_cycle(1'b0, 1'b1);
        do_load(8'h00, 1'b0);
        send_bits(8'h00, 1, 8);
        ack_cycle(1'b0, 1'b0);

        wait_n(4);
        chk("bit_q_drained", bit_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        chk("ack_q_drained", ack_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
